// File: rtl/nwc_stream_frontend.sv
// rtl/nwc_stream_frontend.sv - stream front-end sequencing loads/start of the negacyclic-convolution core and buffering its results
// Optional start-to-first-result latency counter enabled by NWC_FE_PERF_CNT_EN.
module nwc_stream_frontend #(
  parameter int W    = 60,
  parameter int N    = 1024,
  parameter int LOGN = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_coeff0,
  input  logic [W-1:0] s_coeff1,
  output logic [W-1:0] core_data_in0,
  output logic [W-1:0] core_data_in1,
  output logic         core_write_enable,
  output logic         core_start,
  input  logic [W-1:0] core_data_out,
  input  logic         core_output_active,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         m_last,
  output logic         busy,
  output logic         err
`ifdef NWC_FE_PERF_CNT_EN
  , output logic [31:0] perf_latency
`endif
);

  typedef enum logic [1:0] {S_LOAD, S_ARM, S_START, S_RUN} state_t;

  localparam logic [LOGN:0]   N_CNT    = (LOGN+1)'(N);
  localparam logic [LOGN:0]   LAST_CNT = (LOGN+1)'(N-1);
  localparam logic [LOGN:0]   CNT_ONE  = (LOGN+1)'(1);
  localparam logic [LOGN-1:0] PTR_ONE  = LOGN'(1);
  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N-1);

  state_t          state_q, state_d;
  logic [LOGN:0]   ld_cnt_q, ld_cnt_d;
  logic [LOGN:0]   res_cnt_q, res_cnt_d;
  logic [LOGN:0]   fill_q, fill_d;
  logic [LOGN-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOGN-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOGN-1:0] rd_idx_q, rd_idx_d;
  logic [W-1:0]    din0_q, din0_d, din1_q, din1_d;
  logic            we_q, we_d;
  logic            start_q, start_d;
  logic            err_q, err_d;
  logic [W-1:0]    mem_q [N];

  logic            buf_empty;
  logic            buf_wr;
  logic            m_fire;

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    res_cnt_d = res_cnt_q;
    din0_d    = din0_q;
    din1_d    = din1_q;
    we_d      = 1'b0;
    start_d   = 1'b0;
    err_d     = err_q;
    buf_wr    = 1'b0;
    buf_empty = (fill_q == '0);
    m_fire    = !buf_empty && m_ready;

    case (state_q)
      S_LOAD: begin
        if (core_output_active) err_d = 1'b1;
        if (s_valid) begin
          din0_d = s_coeff0;
          din1_d = s_coeff1;
          we_d   = 1'b1;
          if (ld_cnt_q == LAST_CNT) begin
            ld_cnt_d = '0;
            state_d  = S_ARM;
          end else begin
            ld_cnt_d = ld_cnt_q + CNT_ONE;
          end
        end
      end
      // Starting only on an empty buffer guarantees room for all N results.
      S_ARM: begin
        if (core_output_active) err_d = 1'b1;
        if (buf_empty) state_d = S_START;
      end
      S_START: begin
        if (core_output_active) err_d = 1'b1;
        start_d   = 1'b1;
        res_cnt_d = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (res_cnt_q == N_CNT) begin
          if (core_output_active) err_d = 1'b1;
          state_d = S_LOAD;
        end else if (core_output_active) begin
          buf_wr    = 1'b1;
          res_cnt_d = res_cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_LOAD;
    endcase

    wr_ptr_d = buf_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = m_fire ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rd_idx_d = m_fire ? rd_idx_q + PTR_ONE : rd_idx_q;
    fill_d   = fill_q;
    if (buf_wr && !m_fire) fill_d = fill_q + CNT_ONE;
    if (!buf_wr && m_fire) fill_d = fill_q - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOAD;
      ld_cnt_q  <= '0;
      res_cnt_q <= '0;
      fill_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_idx_q  <= '0;
      din0_q    <= '0;
      din1_q    <= '0;
      we_q      <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      res_cnt_q <= res_cnt_d;
      fill_q    <= fill_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_idx_q  <= rd_idx_d;
      din0_q    <= din0_d;
      din1_q    <= din1_d;
      we_q      <= we_d;
      start_q   <= start_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_wr) mem_q[wr_ptr_q] <= core_data_out;
  end

  assign s_ready           = (state_q == S_LOAD);
  assign core_data_in0     = din0_q;
  assign core_data_in1     = din1_q;
  assign core_write_enable = we_q;
  assign core_start        = start_q;
  assign busy              = !((state_q == S_LOAD) && (ld_cnt_q == '0));
  assign err               = err_q;
  assign m_valid           = !buf_empty;
  assign m_data            = buf_empty ? '0 : mem_q[rd_ptr_q];
  assign m_last            = !buf_empty && (rd_idx_q == LAST_IDX);

`ifdef NWC_FE_PERF_CNT_EN
  logic [31:0] pcnt_q, pcnt_d, plat_q, plat_d;
  logic        prun_q, prun_d;

  // The start pulse is cycle 0; the first result beat of the job captures the count.
  always_comb begin
    pcnt_d = pcnt_q;
    plat_d = plat_q;
    prun_d = prun_q;
    if (start_q) begin
      if (core_output_active) begin
        plat_d = '0;
        prun_d = 1'b0;
      end else begin
        pcnt_d = 32'd1;
        prun_d = 1'b1;
      end
    end else if (prun_q) begin
      if (core_output_active) begin
        plat_d = pcnt_q;
        prun_d = 1'b0;
      end else if (pcnt_q != 32'hFFFF_FFFF) begin
        pcnt_d = pcnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      plat_q <= '0;
      prun_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      plat_q <= plat_d;
      prun_q <= prun_d;
    end
  end

  assign perf_latency = plat_q;
`endif

endmodule

// File: tb/tb_nwc_stream_frontend.sv
// tb/tb_nwc_stream_frontend.sv - directed self-checking bench for nwc_stream_frontend (N=8, W=60)
module tb_nwc_stream_frontend;
  localparam int W = 60;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, s_ready;
  logic [W-1:0] s_coeff0, s_coeff1;
  logic [W-1:0] core_data_in0, core_data_in1;
  logic         core_write_enable, core_start;
  logic [W-1:0] core_data_out;
  logic         core_output_active;
  logic         m_valid, m_ready, m_last;
  logic [W-1:0] m_data;
  logic         busy, err;
`ifdef NWC_FE_PERF_CNT_EN
  logic [31:0]  perf_latency;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  logic [W-1:0] beat_data [$];
  logic         beat_last [$];
  int           beat_cyc  [$];

  nwc_stream_frontend #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_coeff0(s_coeff0), .s_coeff1(s_coeff1),
    .core_data_in0(core_data_in0), .core_data_in1(core_data_in1),
    .core_write_enable(core_write_enable), .core_start(core_start),
    .core_data_out(core_data_out), .core_output_active(core_output_active),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err(err)
`ifdef NWC_FE_PERF_CNT_EN
    , .perf_latency(perf_latency)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Beats are sampled mid-cycle; inputs only change just after the rising edge.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      beat_data.push_back(m_data);
      beat_last.push_back(m_last);
      beat_cyc.push_back(cyc);
    end
    if (!rst && core_start) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_job(input int a0, input int b0, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid  = 1'b1;
      s_coeff0 = W'(a0 + i);
      s_coeff1 = W'(b0 + i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_start(output int k);
    k = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (core_start === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic emit(input int base, input logic [7:0] gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps[i]) begin
        core_output_active = 1'b0;
        tick();
      end
      core_output_active = 1'b1;
      core_data_out      = W'(base + i);
      tick();
    end
    core_output_active = 1'b0;
    core_data_out      = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_coeff0 = '0; s_coeff1 = '0;
    core_data_out = '0; core_output_active = 1'b0; m_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({s_ready, core_write_enable, core_start, m_valid, m_last, busy, err} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=1000000", {s_ready, core_write_enable, core_start, m_valid, m_last, busy, err});
    end
    checks++;
    if (core_data_in0 !== '0 || core_data_in1 !== '0 || m_data !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", core_data_in0, core_data_in1, m_data);
    end
`ifdef NWC_FE_PERF_CNT_EN
    checks++;
    if (perf_latency !== 32'd0) begin
      failures++;
      $display("FAIL reset_perf got=%0d exp=0", perf_latency);
    end
`endif
    rst = 1'b0;
    tick();
    checks++;
    if ({s_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=10", {s_ready, busy});
    end
  endtask

  task automatic test_load();
    int k;
    for (int i = 0; i < N; i++) begin
      s_valid  = 1'b1;
      s_coeff0 = W'(i);
      s_coeff1 = W'(100 + i);
      tick();
      checks++;
      if ({core_write_enable, busy} !== 2'b11 || core_data_in0 !== W'(i) || core_data_in1 !== W'(100 + i)) begin
        failures++;
        $display("FAIL load_beat%0d got=we%b busy%b %0d/%0d exp=we1 busy1 %0d/%0d",
                 i, core_write_enable, busy, core_data_in0, core_data_in1, i, 100 + i);
      end
    end
    s_valid = 1'b0;
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL arm_s_ready got=%b exp=0", s_ready);
    end
    wait_start(k);
    checks++;
    if (k != 2) begin
      failures++;
      $display("FAIL start_delay got=%0d exp=2", k);
    end
    tick();
    checks++;
    if ({core_start, core_write_enable} !== 2'b00) begin
      failures++;
      $display("FAIL start_pulse_width got=%b exp=00", {core_start, core_write_enable});
    end
  endtask

  task automatic test_results();
    int nb;
    m_ready = 1'b1;
    nb = beat_data.size();
    emit(32'hA0, 8'b0101_0100);
    repeat (6) tick();
    checks++;
    if (beat_data.size() != nb + N) begin
      failures++;
      $display("FAIL res_count got=%0d exp=%0d", beat_data.size() - nb, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (beat_data[nb+i] !== W'(32'hA0 + i) || beat_last[nb+i] !== (i == N-1)) begin
        failures++;
        $display("FAIL res_beat%0d got=%h last%b exp=%h last%b", i, beat_data[nb+i], beat_last[nb+i], 32'hA0 + i, i == N-1);
      end
    end
    checks++;
    if ({err, busy, m_valid, s_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL res_idle got=%b exp=0001", {err, busy, m_valid, s_ready});
    end
  endtask

  task automatic test_backpressure();
    int k, nb, s0;
    m_ready = 1'b0;
    load_job(10, 200, N);
    wait_start(k);
    checks++;
    if (k < 0) begin
      failures++;
      $display("FAIL bp_start1 got=timeout exp=pulse");
    end
    nb = beat_data.size();
    emit(32'hB0, 8'h00);
    repeat (3) tick();
    checks++;
    if ({m_valid, m_last, s_ready} !== 3'b101 || m_data !== W'(32'hB0)) begin
      failures++;
      $display("FAIL bp_hold got=%b %h exp=101 b0", {m_valid, m_last, s_ready}, m_data);
    end
    s0 = start_cnt;
    load_job(20, 300, N);
    repeat (10) tick();
    checks++;
    if (start_cnt != s0 || s_ready !== 1'b0 || beat_data.size() != nb) begin
      failures++;
      $display("FAIL bp_arm_wait got=starts%0d s_ready%b beats%0d exp=0 0 0", start_cnt - s0, s_ready, beat_data.size() - nb);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 40 && start_cnt == s0; i++) tick();
    checks++;
    if (start_cnt != s0 + 1 || beat_data.size() != nb + N) begin
      failures++;
      $display("FAIL bp_release got=starts%0d beats%0d exp=1 %0d", start_cnt - s0, beat_data.size() - nb, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (beat_data[nb+i] !== W'(32'hB0 + i) || beat_last[nb+i] !== (i == N-1)) begin
        failures++;
        $display("FAIL bp_beat%0d got=%h last%b exp=%h last%b", i, beat_data[nb+i], beat_last[nb+i], 32'hB0 + i, i == N-1);
      end
    end
    checks++;
    if (start_cyc - beat_cyc[nb+N-1] != 3) begin
      failures++;
      $display("FAIL bp_start_after_last got=%0d exp=3", start_cyc - beat_cyc[nb+N-1]);
    end
    nb = beat_data.size();
    emit(32'hC0, 8'b0010_0000);
    repeat (6) tick();
    checks++;
    if (beat_data.size() != nb + N || beat_data[nb+N-1] !== W'(32'hC7) || beat_last[nb+N-1] !== 1'b1
        || beat_data[nb] !== W'(32'hC0) || beat_last[nb] !== 1'b0) begin
      failures++;
      $display("FAIL job3_results got=beats%0d first%h last%h exp=8 c0 c7", beat_data.size() - nb, beat_data[nb], beat_data[nb+N-1]);
    end
  endtask

  task automatic test_error();
    core_output_active = 1'b1;
    core_data_out      = W'(32'h55);
    tick();
    core_output_active = 1'b0;
    core_data_out      = '0;
    tick();
    checks++;
    if ({err, m_valid} !== 2'b10) begin
      failures++;
      $display("FAIL err_set got=%b exp=10", {err, m_valid});
    end
    repeat (5) tick();
    checks++;
    if ({err, m_valid} !== 2'b10) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=10", {err, m_valid});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got=%b exp=0", err);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_midjob_reset();
    int k, nb;
    m_ready = 1'b1;
    load_job(0, 0, 5);
    checks++;
    if ({busy, core_write_enable} !== 2'b11 || core_data_in0 !== W'(4)) begin
      failures++;
      $display("FAIL partial_load got=%b %0d exp=11 4", {busy, core_write_enable}, core_data_in0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s_ready, core_write_enable, core_start, m_valid, m_last, busy, err} !== 7'b1000000
        || core_data_in0 !== '0 || core_data_in1 !== '0 || m_data !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b %h exp=1000000 0", {s_ready, core_write_enable, core_start, m_valid, m_last, busy, err}, core_data_in0);
    end
    tick();
    rst = 1'b0;
    tick();
    nb = beat_data.size();
    load_job(40, 400, N);
    wait_start(k);
    checks++;
    if (k != 2) begin
      failures++;
      $display("FAIL fresh_start got=%0d exp=2", k);
    end
    emit(32'hD0, 8'b0000_0010);
    repeat (6) tick();
    checks++;
    if (beat_data.size() != nb + N) begin
      failures++;
      $display("FAIL fresh_count got=%0d exp=%0d", beat_data.size() - nb, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (beat_data[nb+i] !== W'(32'hD0 + i) || beat_last[nb+i] !== (i == N-1)) begin
        failures++;
        $display("FAIL fresh_beat%0d got=%h last%b exp=%h last%b", i, beat_data[nb+i], beat_last[nb+i], 32'hD0 + i, i == N-1);
      end
    end
    checks++;
    if ({err, busy} !== 2'b00) begin
      failures++;
      $display("FAIL fresh_idle got=%b exp=00", {err, busy});
    end
  endtask

`ifdef NWC_FE_PERF_CNT_EN
  task automatic test_perf();
    int k;
    m_ready = 1'b1;
    load_job(1, 2, N);
    wait_start(k);
    repeat (20) tick();
    emit(32'hE0, 8'h00);
    repeat (6) tick();
    checks++;
    if (k < 0 || perf_latency !== 32'd20) begin
      failures++;
      $display("FAIL perf_latency got=%0d exp=20", perf_latency);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_results();
    test_backpressure();
    test_error();
    test_midjob_reset();
`ifdef NWC_FE_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
